// File: rtl/vdic_serial_alu.sv
// Serial two-operand ALU: receives A, B and an opcode as 10-bit parity
// frames on din and returns status plus a 16-bit result as three frames on dout.
module vdic_serial_alu #(
    parameter int unsigned RSP_GAP = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_n,
    input  logic din,
    output logic dout,
    output logic dout_valid
);

    typedef enum logic [1:0] {IDLE, RX, CALC, TX} state_t;

    localparam logic [7:0] CMD_AND = 8'h01;
    localparam logic [7:0] CMD_ADD = 8'h10;

    state_t      state_q, state_d;
    logic [8:0]  sr_q, sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  frm_cnt_q, frm_cnt_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  status_q, status_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [29:0] tx_sr_q, tx_sr_d;
    logic [4:0]  tx_cnt_q, tx_cnt_d;
    logic        dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        arm_q, arm_d;

    logic [9:0]  frame_w;
    logic [7:0]  data_w;
    logic        par_err;
    logic        seq_err;
    logic [29:0] rsp_w;

    function automatic logic [9:0] mk_frame(input logic t, input logic [7:0] d);
        return {t, d, ^{t, d}};
    endfunction

    assign frame_w = {sr_q, din};
    assign data_w  = frame_w[8:1];
    assign par_err = ^frame_w;
    assign seq_err = (frm_cnt_q == 2'd2) ? ~frame_w[9] : frame_w[9];
    assign rsp_w   = {mk_frame(1'b1, status_q),
                      mk_frame(1'b0, result_q[15:8]),
                      mk_frame(1'b0, result_q[7:0])};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        frm_cnt_d = frm_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        status_d  = status_q;
        result_d  = result_q;
        gap_cnt_d = gap_cnt_q;
        tx_sr_d   = tx_sr_q;
        tx_cnt_d  = tx_cnt_q;
        dout_d    = 1'b0;
        valid_d   = 1'b0;
        arm_d     = arm_q;
        unique case (state_q)
            IDLE: begin
                // A stream already running when we got here is not a new frame
                if (enable_n) begin
                    arm_d = 1'b1;
                end else if (arm_q) begin
                    state_d   = RX;
                    sr_d      = {8'd0, din};
                    bit_cnt_d = 4'd1;
                    frm_cnt_d = 2'd0;
                end
            end
            RX: begin
                if (enable_n) begin
                    state_d   = IDLE;
                    arm_d     = 1'b1;
                    bit_cnt_d = 4'd0;
                    frm_cnt_d = 2'd0;
                    sr_d      = '0;
                end else if (bit_cnt_q == 4'd9) begin
                    bit_cnt_d = 4'd0;
                    sr_d      = '0;
                    if (par_err || seq_err || frm_cnt_q == 2'd2) begin
                        state_d   = CALC;
                        gap_cnt_d = 4'd0;
                        result_d  = 16'h0000;
                        status_d  = 8'h00;
                        if (par_err) begin
                            status_d = 8'h40;
                        end else if (seq_err) begin
                            status_d = 8'h20;
                        end else if (data_w == CMD_AND) begin
                            result_d = {8'd0, a_q & b_q};
                        end else if (data_w == CMD_ADD) begin
                            result_d = {7'd0, {1'b0, a_q} + {1'b0, b_q}};
                        end else begin
                            status_d = 8'h80;
                        end
                    end else if (frm_cnt_q == 2'd0) begin
                        a_d       = data_w;
                        frm_cnt_d = 2'd1;
                    end else begin
                        b_d       = data_w;
                        frm_cnt_d = 2'd2;
                    end
                end else begin
                    sr_d      = {sr_q[7:0], din};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            CALC: begin
                if (gap_cnt_q == 4'(RSP_GAP)) begin
                    state_d  = TX;
                    dout_d   = rsp_w[29];
                    valid_d  = 1'b1;
                    tx_sr_d  = {rsp_w[28:0], 1'b0};
                    tx_cnt_d = 5'd1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            TX: begin
                if (tx_cnt_q == 5'd30) begin
                    state_d  = IDLE;
                    arm_d    = 1'b0;
                    tx_cnt_d = 5'd0;
                    tx_sr_d  = '0;
                end else begin
                    dout_d   = tx_sr_q[29];
                    valid_d  = 1'b1;
                    tx_sr_d  = {tx_sr_q[28:0], 1'b0};
                    tx_cnt_d = tx_cnt_q + 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            frm_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            status_q  <= '0;
            result_q  <= '0;
            gap_cnt_q <= '0;
            tx_sr_q   <= '0;
            tx_cnt_q  <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            arm_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            status_q  <= status_d;
            result_q  <= result_d;
            gap_cnt_q <= gap_cnt_d;
            tx_sr_q   <= tx_sr_d;
            tx_cnt_q  <= tx_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            arm_q     <= arm_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_vdic_serial_alu.sv
// Directed bench for vdic_serial_alu: ADD/AND/bad op, parity and
// sequence errors, mid-frame abort and reset during a response.
module tb_vdic_serial_alu;

    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable_n = 1'b1;
    logic din = 1'b0;
    logic dout;
    logic dout_valid;

    int total = 0;
    int bad = 0;

    logic [29:0] rsp;
    int lat;
    int vcnt;
    int seen;

    vdic_serial_alu #(.RSP_GAP(GAP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable_n(enable_n),
        .din(din),
        .dout(dout),
        .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] fr(input logic t, input logic [7:0] d);
        return {t, d, ^{t, d}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [9:0] f);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            enable_n = 1'b0;
            din = f[i];
        end
    endtask

    // Starts at the negedge where the last request bit is driven.
    task automatic collect(input bit rel, output logic [29:0] r,
                           output int l, output int v);
        r = '0;
        l = 0;
        v = 0;
        @(negedge clk);
        if (rel) begin
            enable_n = 1'b1;
            din = 1'b0;
        end
        while (!dout_valid && l < 60) begin
            @(negedge clk);
            l++;
        end
        while (dout_valid && v < 40) begin
            r = {r[28:0], dout};
            v++;
            @(negedge clk);
        end
    endtask

    task automatic run_req(input string tag, input logic [9:0] fa,
                           input logic [9:0] fb, input logic [9:0] fo,
                           input logic [29:0] exp);
        send_frame(fa);
        send_frame(fb);
        send_frame(fo);
        collect(1'b1, rsp, lat, vcnt);
        chk({tag, "_lat"}, lat, GAP + 1);
        chk({tag, "_len"}, vcnt, 30);
        chk({tag, "_rsp"}, {2'b0, rsp}, {2'b0, exp});
        chk({tag, "_idle_dout"}, {31'd0, dout}, 32'd0);
    endtask

    initial begin
        #1;
        chk("reset_dout", {31'd0, dout}, 32'd0);
        chk("reset_valid", {31'd0, dout_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_req("add", 10'b0_00010010_0, 10'b0_11111111_0, 10'b1_00010000_0,
                {10'b1_00000000_1, 10'b0_00000001_1, 10'b0_00010001_0});

        run_req("and", fr(1'b0, 8'hF0), fr(1'b0, 8'h3C), fr(1'b1, 8'h01),
                {10'b1_00000000_1, 10'b0_00000000_0, 10'b0_00110000_0});

        run_req("badop", fr(1'b0, 8'h01), fr(1'b0, 8'h02), 10'b1_00000111_0,
                {10'b1_10000000_0, 10'b0_00000000_0, 10'b0_00000000_0});

        // Parity flipped on B; the control frame is driven during CALC/TX.
        send_frame(10'b0_00000001_1);
        send_frame(10'b0_00000010_0);
        fork
            send_frame(10'b1_00010000_0);
            collect(1'b0, rsp, lat, vcnt);
        join
        enable_n = 1'b1;
        din = 1'b0;
        chk("par_lat", lat, GAP + 1);
        chk("par_len", vcnt, 30);
        chk("par_rsp", {2'b0, rsp},
            {2'b0, 10'b1_01000000_0, 10'b0_00000000_0, 10'b0_00000000_0});
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout_valid) seen++;
        end
        chk("par_no_extra", seen, 0);

        // Abort after five bits of A.
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk);
            enable_n = 1'b0;
            din = 1'b1;
        end
        @(negedge clk);
        enable_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout_valid) seen++;
        end
        chk("abort_quiet", seen, 0);
        run_req("add00", 10'b0_00000000_0, 10'b0_00000000_0, 10'b1_00010000_0,
                {10'b1_00000000_1, 10'b0_00000000_0, 10'b0_00000000_0});

        // Control frame as frame 1.
        send_frame(10'b1_00010000_0);
        collect(1'b1, rsp, lat, vcnt);
        chk("seq_lat", lat, GAP + 1);
        chk("seq_len", vcnt, 30);
        chk("seq_rsp", {2'b0, rsp},
            {2'b0, 10'b1_00100000_0, 10'b0_00000000_0, 10'b0_00000000_0});

        // Reset pulse at response bit 12.
        send_frame(fr(1'b0, 8'h12));
        send_frame(fr(1'b0, 8'hFF));
        send_frame(fr(1'b1, 8'h10));
        @(negedge clk);
        enable_n = 1'b1;
        lat = 0;
        while (!dout_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        repeat (12) @(negedge clk);
        chk("rst_pre_valid", {31'd0, dout_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_dout", {31'd0, dout}, 32'd0);
        chk("rst_async_valid", {31'd0, dout_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout_valid) seen++;
        end
        chk("rst_no_resume", seen, 0);
        run_req("post_rst", fr(1'b0, 8'h12), fr(1'b0, 8'hFF), fr(1'b1, 8'h10),
                {10'b1_00000000_1, 10'b0_00000001_1, 10'b0_00010001_0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vdic_serial_alu.md
VDIC_SERIAL_ALU -- requirements
Module: vdic_serial_alu

Interface
REQ-001 Parameter: RSP_GAP, default 2, idle cycles between the last sampled bit of the command frame and the first response bit (legal 1..15).
REQ-002 Port: clk  in  1  clock, all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: enable_n  in  1  active-low frame enable; din is sampled only while low.
REQ-005 Port: din  in  1  serial request data, MSB first.
REQ-006 Port: dout  out  1  serial response data, MSB first.
REQ-007 Port: dout_valid  out  1  high during every response bit.

Function
REQ-008 Frame format SHALL be 10 bits, MSB first: {type, data[7:0], parity}; type 1 = control, type 0 = data.
REQ-009 Parity SHALL be the XOR of bits 9..1, i.e. even parity over type+data; the same rule applies to received and transmitted frames.
REQ-010 The block SHALL shift din in on each rising clk edge where enable_n=0; frames are back-to-back with no gap bits; a 4-bit counter (0..9) marks frame completion.
REQ-011 The request sequence SHALL be data frame A, data frame B, control frame OP.
REQ-012 The state machine SHALL have states IDLE, RX, CALC, TX: IDLE->RX on the first sample with enable_n=0; RX->CALC on command-frame completion or on a detected error; CALC->TX after RSP_GAP cycles; TX->IDLE after 30 bits.
REQ-013 A rising edge of enable_n in mid-frame (bit counter != 0) or between frames of an incomplete sequence SHALL discard all received frames and return to IDLE with no response.
REQ-014 enable_n and din SHALL be ignored in CALC and TX; a request started then is not captured.
REQ-015 Opcodes SHALL be CMD_AND=0x01 (A & B) and CMD_ADD=0x10 (A + B, 9-bit carry-preserving sum); the result is zero-extended to 16 bits.
REQ-016 Status codes SHALL be: 0x00 no error, 0x80 invalid command (unknown opcode), 0x40 parity error (any frame), 0x20 invalid sequence (control frame as frame 1 or 2, or data frame as frame 3).
REQ-017 Error precedence SHALL be parity > sequence > command; on any error the result SHALL be 0x0000.
REQ-018 Parity and sequence errors SHALL end reception at the offending frame and go to CALC immediately; remaining request bits are ignored until the response completes.
REQ-019 The response SHALL be three back-to-back frames: status (type 1), result[15:8] (type 0), result[7:0] (type 0), each with parity per REQ-009.
REQ-020 dout SHALL change only on rising clk edges; dout_valid SHALL be high for exactly 30 consecutive cycles per response; dout SHALL be 0 whenever dout_valid is 0.
REQ-021 Latency SHALL be: the first response bit appears RSP_GAP+1 rising edges after the edge sampling the last request bit.

Reset
REQ-022 While rst_n=0: state=IDLE, all counters and shift registers cleared, dout=0, dout_valid=0, immediately and regardless of clk.
REQ-023 Reset asserted in RX, CALC or TX SHALL abort the operation; no partial response SHALL resume after release.
REQ-024 The first enable_n=0 sample after reset release SHALL be bit 9 of a new frame 1.

Verification
REQ-025 ADD: frames 0_00010010_0 (0x12), 0_11111111_0 (0xFF), 1_00010000_0 (0x10) -> response 1_00000000_1, 0_00000001_1, 0_00010001_0 (result 0x0111), dout_valid high for 30 cycles starting 3 cycles after the last bit.
REQ-026 AND: A=0xF0, B=0x3C, op 0x01 -> status 0x00, result 0x0030; all three response frames have valid parity.
REQ-027 Bad opcode 0x07 with A=0x01, B=0x02 -> status frame 1_10000000_0, result 0x0000.
REQ-028 Flipped parity bit on frame B -> response begins RSP_GAP+1 cycles after frame B ends, with status 0x40 and result 0x0000; the control frame that follows is ignored.
REQ-029 enable_n raised after bit 5 of frame A, then a clean ADD 0x00+0x00 -> no response to the aborted request, then status 0x00 and result 0x0000.
REQ-030 rst_n pulsed low at bit 12 of the response -> dout and dout_valid drop to 0 asynchronously; the next request returns a correct, complete response.
